// File: rtl/psum_requant_pack_pkg.sv
// Shared encodings and constants for the PSUM requantise/pack stage.
package psum_requant_pack_pkg;

  localparam logic [1:0] PREC_2B = 2'b00;
  localparam logic [1:0] PREC_4B = 2'b01;
  localparam logic [1:0] PREC_8B = 2'b10;

  localparam int LANES_2B = 4;
  localparam int LANES_4B = 2;
  localparam int LANES_8B = 1;

  localparam logic signed [7:0] SAT_MAX_2B = 8'sh01;
  localparam logic signed [7:0] SAT_MIN_2B = 8'shFE;
  localparam logic signed [7:0] SAT_MAX_4B = 8'sh07;
  localparam logic signed [7:0] SAT_MIN_4B = 8'shF8;
  localparam logic signed [7:0] SAT_MAX_8B = 8'sh7F;
  localparam logic signed [7:0] SAT_MIN_8B = 8'sh80;

  // Code 2'b11 is an alias of the 8b precision.
  function automatic logic [1:0] prec_norm(input logic [1:0] f);
    return (f == 2'b11) ? PREC_8B : f;
  endfunction

  function automatic logic [1:0] lane_last(input logic [1:0] prec);
    case (prec)
      PREC_2B: return 2'(LANES_2B - 1);
      PREC_4B: return 2'(LANES_4B - 1);
      default: return 2'(LANES_8B - 1);
    endcase
  endfunction

endpackage

// File: rtl/psum_requant_pack_fifo.sv
// First-word-fall-through FIFO; head visible combinationally, 1-cycle push-to-head.
// A push at full is accepted only when a pop frees the head slot in the same cycle.
module sync_fifo_fwft #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   i_push,
  input  logic [W-1:0]           i_push_dat,
  input  logic                   i_pop,
  output logic [W-1:0]           o_head_dat,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_pop;
  logic          w_push;

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == (AW+1)'(DEPTH));
  assign w_pop      = i_pop && !o_empty;
  assign w_push     = i_push && (!o_full || w_pop);
  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_count    = r_count;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/psum_requant_pack.sv
// Round/shift, saturate and pack finished PSUMs into 8b words; i_Done at t pushes at end of t+2.
// Valid/ready FIFO output; o_Almost_Full throttles upstream. ReLU option: PSUM_REQUANT_RELU_EN.
module psum_requant_pack
  import psum_requant_pack_pkg::*;
#(
  parameter int BITS_IN    = 24,
  parameter int BITS_OUT   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic signed [BITS_IN-1:0] i_Psum,
  input  logic                      i_Done,
  input  logic [3:0]                i_Precision,
  input  logic [3:0]                i_Shift,
  input  logic                      i_Relu,
  input  logic                      i_Flush_Pack,
  output logic [BITS_OUT-1:0]       o_Data,
  output logic                      o_Valid,
  input  logic                      i_Ready,
  output logic                      o_Almost_Full,
  output logic                      o_Overflow,
  output logic                      o_Sat
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                      r_s1_vld;
  logic signed [BITS_IN-1:0] r_s1_psum;
  logic [3:0]                r_s1_shift;
  logic [1:0]                r_s1_prec;
  logic                      r_s2_vld;
  logic [BITS_OUT-1:0]       r_s2_dat;
  logic [1:0]                r_s2_prec;
  logic [1:0]                r_lane_cnt;
  logic [BITS_OUT-1:0]       r_pack;
  logic                      r_ovf;
  logic                      r_sat;

  logic signed [BITS_IN:0]   w_ext, w_rnd, w_shr, w_max, w_min;
  logic signed [7:0]         w_max8, w_min8;
  logic [BITS_OUT-1:0]       w_res;
  logic                      w_clamp;
  logic [BITS_OUT-1:0]       w_pack_nxt, w_push_dat, w_head;
  logic [1:0]                w_cnt_nxt;
  logic                      w_push, w_pop, w_full, w_empty;
  logic [CW-1:0]             w_count;
  logic                      w_unused_prec;

  assign w_unused_prec = ^i_Precision[1:0];

`ifdef PSUM_REQUANT_RELU_EN
  logic r_s1_relu;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)        r_s1_relu <= 1'b0;
    else if (i_Done) r_s1_relu <= i_Relu;
  end
`else
  logic w_unused_relu;
  assign w_unused_relu = i_Relu;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_s1_vld   <= 1'b0;
      r_s1_psum  <= '0;
      r_s1_shift <= '0;
      r_s1_prec  <= PREC_2B;
    end else begin
      r_s1_vld <= i_Done;
      if (i_Done) begin
        r_s1_psum  <= i_Psum;
        r_s1_shift <= i_Shift;
        r_s1_prec  <= prec_norm(i_Precision[3:2]);
      end
    end
  end

  // One extra bit of headroom keeps the rounding add from wrapping.
  always_comb begin
    w_ext = {r_s1_psum[BITS_IN-1], r_s1_psum};
    w_rnd = '0;
    if (r_s1_shift != 4'd0) w_rnd = (BITS_IN+1)'(1) << (r_s1_shift - 4'd1);
    w_shr = (w_ext + w_rnd) >>> r_s1_shift;
`ifdef PSUM_REQUANT_RELU_EN
    if (r_s1_relu && w_shr[BITS_IN]) w_shr = '0;
`endif
    case (r_s1_prec)
      PREC_2B: begin w_max8 = SAT_MAX_2B; w_min8 = SAT_MIN_2B; end
      PREC_4B: begin w_max8 = SAT_MAX_4B; w_min8 = SAT_MIN_4B; end
      default: begin w_max8 = SAT_MAX_8B; w_min8 = SAT_MIN_8B; end
    endcase
    w_max   = (BITS_IN+1)'(w_max8);
    w_min   = (BITS_IN+1)'(w_min8);
    w_clamp = 1'b0;
    w_res   = w_shr[BITS_OUT-1:0];
    if (w_shr > w_max) begin
      w_res   = w_max8;
      w_clamp = 1'b1;
    end else if (w_shr < w_min) begin
      w_res   = w_min8;
      w_clamp = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_s2_vld  <= 1'b0;
      r_s2_dat  <= '0;
      r_s2_prec <= PREC_2B;
      r_sat     <= 1'b0;
    end else begin
      r_s2_vld <= r_s1_vld;
      r_sat    <= r_sat | (r_s1_vld & w_clamp);
      if (r_s1_vld) begin
        r_s2_dat  <= w_res;
        r_s2_prec <= r_s1_prec;
      end
    end
  end

  // A result is merged before a coincident flush, so the two never push twice.
  always_comb begin
    w_pack_nxt = r_pack;
    w_cnt_nxt  = r_lane_cnt;
    w_push     = 1'b0;
    w_push_dat = r_pack;
    if (r_s2_vld) begin
      case (r_s2_prec)
        PREC_2B: w_pack_nxt[{r_lane_cnt, 1'b0} +: 2]    = r_s2_dat[1:0];
        PREC_4B: w_pack_nxt[{r_lane_cnt[0], 2'b00} +: 4] = r_s2_dat[3:0];
        default: w_pack_nxt = r_s2_dat;
      endcase
      if (r_lane_cnt == lane_last(r_s2_prec)) begin
        w_push     = 1'b1;
        w_push_dat = w_pack_nxt;
        w_pack_nxt = '0;
        w_cnt_nxt  = 2'd0;
      end else begin
        w_cnt_nxt = r_lane_cnt + 2'd1;
      end
    end
    if (i_Flush_Pack && (w_cnt_nxt != 2'd0)) begin
      w_push     = 1'b1;
      w_push_dat = w_pack_nxt;
      w_pack_nxt = '0;
      w_cnt_nxt  = 2'd0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_lane_cnt <= 2'd0;
      r_pack     <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_lane_cnt <= w_cnt_nxt;
      r_pack     <= w_pack_nxt;
      r_ovf      <= r_ovf | (w_push & w_full & ~w_pop);
    end
  end

  sync_fifo_fwft #(.W(BITS_OUT), .DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK        (CLK),
    .RST        (RST),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  assign o_Valid       = !w_empty;
  assign w_pop         = o_Valid && i_Ready;
  assign o_Data        = w_empty ? '0 : w_head;
  assign o_Almost_Full = (w_count > CW'(FIFO_DEPTH - 3));
  assign o_Overflow    = r_ovf;
  assign o_Sat         = r_sat;

endmodule

// File: tb/tb_psum_requant_pack.sv
// Self-checking bench for psum_requant_pack: vector table plus hand-built corner sequences.
module tb_psum_requant_pack;
  localparam int BITS_IN = 24;

  logic               CLK = 1'b0;
  logic               RST = 1'b0;
  logic [BITS_IN-1:0] i_Psum;
  logic               i_Done, i_Relu, i_Flush_Pack, i_Ready;
  logic [3:0]         i_Precision, i_Shift;
  logic [7:0]         o_Data;
  logic               o_Valid, o_Almost_Full, o_Overflow, o_Sat;

  always #5 CLK = ~CLK;

  psum_requant_pack #(.BITS_IN(BITS_IN), .BITS_OUT(8), .FIFO_DEPTH(4)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .i_Psum        (i_Psum),
    .i_Done        (i_Done),
    .i_Precision   (i_Precision),
    .i_Shift       (i_Shift),
    .i_Relu        (i_Relu),
    .i_Flush_Pack  (i_Flush_Pack),
    .o_Data        (o_Data),
    .o_Valid       (o_Valid),
    .i_Ready       (i_Ready),
    .o_Almost_Full (o_Almost_Full),
    .o_Overflow    (o_Overflow),
    .o_Sat         (o_Sat)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] sb_q[$];

  typedef struct {
    logic [1:0] prec;
    logic [3:0] shift;
    int         psum;
    logic [7:0] dat;
    logic       sat;
  } vec_t;
  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [1:0] prec, input logic [3:0] sh, input int psum);
    i_Precision = {prec, 2'b00};
    i_Shift     = sh;
    i_Psum      = psum[BITS_IN-1:0];
    i_Done      = 1'b1;
    step(1);
    i_Done      = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 50 && (sb_q.size() != 0 || o_Valid); i++) step(1);
    check(name, sb_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, o_Valid, 0);
    check({tag, "_data"}, o_Data, 0);
    check({tag, "_afull"}, o_Almost_Full, 0);
    check({tag, "_ovf"}, o_Overflow, 0);
    check({tag, "_sat"}, o_Sat, 0);
  endtask

  // Scoreboard: every accepted output word must match the oldest expectation.
  always @(negedge CLK) begin
    if (RST && o_Valid && i_Ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_word: got %02h, no word expected", o_Data);
      end else begin
        check("out_data", o_Data, sb_q.pop_front());
      end
    end
  end

  initial begin
    i_Psum = '0; i_Done = 0; i_Relu = 0; i_Flush_Pack = 0; i_Ready = 1;
    i_Precision = 4'b1000; i_Shift = 4'd0;
    step(2);
    check_reset_outputs("reset");
    RST = 1'b1;
    step(1);

    vecs[0] = '{2'b10, 4'd4,  1000,    8'h3F, 1'b0};
    vecs[1] = '{2'b10, 4'd2,  6,       8'h02, 1'b0};
    vecs[2] = '{2'b10, 4'd2,  -6,      8'hFF, 1'b0};
    vecs[3] = '{2'b10, 4'd1,  -1,      8'h00, 1'b0};
    vecs[4] = '{2'b11, 4'd0,  127,     8'h7F, 1'b0};
    vecs[5] = '{2'b10, 4'd0,  -128,    8'h80, 1'b0};
    vecs[6] = '{2'b10, 4'd4,  5000,    8'h7F, 1'b1};
    vecs[7] = '{2'b10, 4'd4,  -5000,   8'h80, 1'b1};
    vecs[8] = '{2'b10, 4'd15, 4194304, 8'h7F, 1'b1};

    for (int i = 0; i < 9; i++) begin
      sb_q.push_back(vecs[i].dat);
      send(vecs[i].prec, vecs[i].shift, vecs[i].psum);
      if (i == 0) begin
        step(1);
        check("lat_t2_valid", o_Valid, 0);
        step(1);
        check("lat_t3_valid", o_Valid, 1);
      end
      drain("vec_drain");
      check("vec_sat", o_Sat, vecs[i].sat);
    end

    RST = 1'b0; step(1); RST = 1'b1; step(1);
    check("sat_cleared", o_Sat, 0);

    // 2b: four lanes, the third one saturates.
    sb_q.push_back(8'h9D);
    send(2'b00, 4'd0, 1);
    send(2'b00, 4'd0, -1);
    send(2'b00, 4'd0, 2);
    send(2'b00, 4'd0, -2);
    drain("pack2_drain");
    check("pack2_sat", o_Sat, 1);

    // 4b: one lane then flush.
    sb_q.push_back(8'h03);
    send(2'b01, 4'd0, 3);
    step(2);
    check("partial_held", o_Valid, 0);
    i_Flush_Pack = 1; step(1); i_Flush_Pack = 0;
    drain("flush_drain");
    i_Flush_Pack = 1; step(1); i_Flush_Pack = 0;
    step(4);
    check("flush_empty_novalid", o_Valid, 0);

    // Flush on the last lane: exactly one word.
    sb_q.push_back(8'h65);
    send(2'b01, 4'd0, 5);
    send(2'b01, 4'd0, 6);
    step(1);
    i_Flush_Pack = 1; step(1); i_Flush_Pack = 0;
    drain("flush_last_drain");

    // Flush with a mid-word result: result packed first.
    sb_q.push_back(8'h0D);
    send(2'b00, 4'd0, 1);
    send(2'b00, 4'd0, -1);
    step(1);
    i_Flush_Pack = 1; step(1); i_Flush_Pack = 0;
    drain("flush_mid_drain");
    step(4);
    check("no_extra_word", o_Valid, 0);

    // Fill with consumer stalled, then overflow.
    i_Ready = 0;
    for (int k = 1; k <= 4; k++) begin
      sb_q.push_back(8'(k));
      send(2'b10, 4'd0, k);
      step(2);
      check("almost_full", o_Almost_Full, (k >= 2));
    end
    check("ovf_before", o_Overflow, 0);
    send(2'b10, 4'd0, 5);
    step(2);
    check("ovf_set", o_Overflow, 1);
    check("ovf_head_kept", o_Data, 8'h01);
    i_Ready = 1;
    drain("ovf_drain");

    // Reset with two buffered words and a result in S2.
    i_Ready = 0;
    sb_q.push_back(8'h11);
    sb_q.push_back(8'h22);
    send(2'b10, 4'd0, 8'h11);
    send(2'b10, 4'd0, 8'h22);
    send(2'b10, 4'd0, 8'h33);
    step(1);
    check("pre_rst_afull", o_Almost_Full, 1);
    RST = 1'b0;
    #1;
    sb_q.delete();
    check_reset_outputs("midrst");
    step(1);
    RST = 1'b1;
    i_Ready = 1;
    step(1);
    sb_q.push_back(8'h44);
    send(2'b10, 4'd0, 8'h44);
    step(1);
    check("rst_lat_t2_valid", o_Valid, 0);
    step(1);
    check("rst_lat_t3_valid", o_Valid, 1);
    drain("rst_drain");
    step(4);
    check("rst_no_stale", o_Valid, 0);

`ifdef PSUM_REQUANT_RELU_EN
    i_Relu = 1;
    sb_q.push_back(8'h00);
    send(2'b10, 4'd0, -40);
    drain("relu_drain");
    check("relu_sat", o_Sat, 0);
    i_Relu = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/psum_requant_pack.md
Name: psum_requant_pack

Overview:
- Downstream stage of the 64-multiplier fused PE array.
- Captures each finished accumulation (PSUM value qualified by the array's done strobe) and applies a rounding right-shift.
- Saturates the result to the output activation precision (2/4/8b) and packs results into 8-bit activation words.
- Buffers packed words in a small FIFO with a valid/ready handshake towards the activation write-back buffer.

Parameters:
- BITS_IN, 24, width of the incoming signed PSUM (matches the array's PSUM width).
- BITS_OUT, 8, packed output word width; fixed at 8 (one 8b, two 4b or four 2b results).
- FIFO_DEPTH, 4, packed-word FIFO entries; power of two, at least 4.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-low.
- i_Psum  in  BITS_IN  signed finished accumulation from the PE array.
- i_Done  in  1  i_Psum holds a finished sum this cycle; one result per high cycle.
- i_Precision  in  4  same encoding as the array; bits [3:2] give output act precision: 00=2b, 01=4b, 10=8b, 11 treated as 8b.
- i_Shift  in  4  right-shift amount, 0..15.
- i_Relu  in  1  ReLU enable; used only with the optional feature.
- i_Flush_Pack  in  1  emit the partially filled pack word.
- o_Data  out  8  packed output word (FIFO head).
- o_Valid  out  1  o_Data valid.
- i_Ready  in  1  consumer accepts o_Data when o_Valid && i_Ready.
- o_Almost_Full  out  1  fewer than 3 free FIFO entries; upstream must not raise i_Done.
- o_Overflow  out  1  sticky: a push hit a full FIFO.
- o_Sat  out  1  sticky: at least one result saturated.

Behaviour:
- Reset (RST low, asynchronous): all pipeline valids 0, pack lane count 0, pack register 0, FIFO empty. o_Data=0, o_Valid=0, o_Almost_Full=0, o_Overflow=0, o_Sat=0. Reset mid-operation discards all in-flight and buffered data.
- S1, capture: on i_Done, register i_Psum, i_Shift and the precision field.
- S2, round and shift:
  - Compute in BITS_IN+1 bits: r = (p + (i_Shift>0 ? 2^(i_Shift-1) : 0)) >>> i_Shift, arithmetic shift.
  - Saturate r to signed N bits, N = 2/4/8: range [-2^(N-1), 2^(N-1)-1].
  - Set o_Sat when clamping occurs.
- S3, pack:
  - Lanes per word L = 8/N: L=4 for 2b, 2 for 4b, 1 for 8b.
  - Lane k occupies bits [N*k +: N], filled LSB-first.
  - When lane L-1 is written, push the word to the FIFO and clear the lane count.
- Latency: i_Done in cycle t gives the FIFO push at the end of t+2. If the FIFO was empty, o_Valid rises in t+3 (8b mode, or last lane of a word).
- Flush:
  - i_Flush_Pack with lane count > 0 pushes the current word; unfilled upper lanes are 0.
  - With lane count 0 it does nothing.
  - If the last lane and the flush land in the same cycle, only one push occurs.
  - If a flush and a new S2 result coincide, the result is packed first, then the flush applies.
- FIFO:
  - First-word-fall-through; o_Data is the head entry.
  - Pop on o_Valid && i_Ready. Simultaneous push and pop at full is legal and keeps the count.
  - Push at full without a pop: the word is dropped and o_Overflow is set. Contents are unchanged.
- Precision and shift may change only when the pipeline and the pack register are empty; behaviour is otherwise undefined.
- o_Almost_Full is combinational from the FIFO count (count > FIFO_DEPTH-3). This covers the 3 in-flight results.

Optional Feature:
- Macro: PSUM_REQUANT_RELU_EN.
- Defined: in S2, when i_Relu=1, negative r becomes 0 before saturation; the upper bound is unchanged. Forcing a negative value to 0 does not set o_Sat.
- Undefined: i_Relu is ignored and the ReLU logic is absent.

Decomposition:
- Shared package holds:
  - output-precision encodings (2b/4b/8b codes);
  - lanes-per-word constants (4/2/1);
  - N-bit saturation bounds.
- One sub-module: sync_fifo_fwft (parameterised width and depth; count, full and empty flags).

Test Plan:
- 8b mode, shift 4, i_Psum=1000, i_Done in cycle t -> o_Data=8'h3F, o_Valid high in t+3; o_Sat stays 0.
- 8b mode, shift 4, i_Psum=5000 -> o_Data=8'h7F, o_Sat=1. Then i_Psum=-5000 -> 8'h80.
- 2b mode, shift 0, four results 1, -1, 2, -2 -> single word 8'h9D (2 saturates to 1), o_Sat=1.
- 4b mode, one result 3, then i_Flush_Pack -> o_Data=8'h03; no second word appears.
- i_Ready=0, push 4 words -> o_Almost_Full high from count 2. A 5th push -> o_Overflow=1 and the FIFO still holds the first 4 in order.
- RST pulsed low while 2 words are buffered and S2 is valid -> outputs return to reset values immediately; after release, the next result appears with the normal latency.
- With PSUM_REQUANT_RELU_EN: i_Relu=1, i_Psum=-40 -> 8'h00, o_Sat=0.
